// File: rtl/irrig_scheduler.sv
// irrig_scheduler: tank-sharing irrigation FSM with round-robin zones, fertilizer dosing and line flush.
module irrig_scheduler #(
  parameter int IRRIG_TICKS = 8,
  parameter int DOSE_TICKS  = 2,
  parameter int CLEAN_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       req_asp,
  input  logic       req_got,
  input  logic       adb,
  input  logic [2:0] nivel,
  output logic       VE,
  output logic       grant_asp,
  output logic       grant_got,
  output logic       dose,
  output logic       limpeza,
  output logic       slot_done,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE = 3'b000, FILL = 3'b001, ASP = 3'b010, GOT = 3'b011, CLEAN = 3'b100} state_t;
  localparam logic [7:0] IRRIG_T = 8'(IRRIG_TICKS);
  localparam logic [7:0] DOSE_T  = 8'(DOSE_TICKS);
  localparam logic [7:0] CLEAN_T = 8'(CLEAN_TICKS);
  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d, timer_inc;
  logic       dosed_q, dosed_d, last_q, last_d, done_q, done_d;
  logic       empty, full, own;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      dosed_q <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dosed_q <= dosed_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end
  // Non-thermometer level codes are treated as an empty tank.
  assign empty     = !(nivel == 3'b001 || nivel == 3'b011 || nivel == 3'b111);
  assign full      = nivel == 3'b111;
  assign own       = state_q == ASP ? req_asp : req_got;
  assign timer_inc = timer_q == 8'hff ? timer_q : timer_q + 8'd1;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dosed_d = dosed_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (empty) state_d = FILL;
        else if (req_asp && (!req_got || last_q)) begin
          state_d = ASP;
          timer_d = '0;
          dosed_d = adb;
          last_d  = 1'b0;
        end else if (req_got) begin
          state_d = GOT;
          timer_d = '0;
          dosed_d = 1'b0;
          last_d  = 1'b1;
        end
      end
      FILL: begin
        if (full) begin
          state_d = dosed_q ? CLEAN : IDLE;
          timer_d = '0;
        end
      end
      ASP, GOT: begin
        if (empty) state_d = FILL;
        else if (!own) begin
          state_d = dosed_q ? CLEAN : IDLE;
          timer_d = '0;
        end else if (tick) begin
          timer_d = timer_inc;
          if (timer_inc == IRRIG_T) begin
            state_d = dosed_q ? CLEAN : IDLE;
            timer_d = '0;
            done_d  = 1'b1;
          end
        end
      end
      CLEAN: begin
        if (tick) begin
          timer_d = timer_inc;
          if (timer_inc == CLEAN_T) begin
            state_d = IDLE;
            timer_d = '0;
            dosed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    VE        = state_q == FILL;
    grant_asp = state_q == ASP;
    grant_got = state_q == GOT;
    limpeza   = state_q == CLEAN;
    dose      = state_q == ASP && dosed_q && timer_q < DOSE_T;
    slot_done = done_q;
    state     = state_q;
  end
endmodule

// File: tb/tb_irrig_scheduler.sv
// tb_irrig_scheduler: random stimulus checked cycle by cycle against a countdown-based reference model.
module tb_irrig_scheduler;
  localparam int IRRIG = 8, DOSE = 2, CLEAN = 4;
  logic clock = 1'b0, reset = 1'b0, tick = 1'b0, req_asp = 1'b0, req_got = 1'b0, adb = 1'b0;
  logic [2:0] nivel = 3'b111;
  logic VE, grant_asp, grant_got, dose, limpeza, slot_done;
  logic [2:0] state;
  int checks = 0, errors = 0, cyc = 0;
  int m_mode = 0, m_left = 0;
  bit m_fert = 0, m_asp_next = 1, m_done = 0;
  int n_done = 0, n_asp = 0, n_got = 0, n_clean = 0;
  irrig_scheduler #(.IRRIG_TICKS(IRRIG), .DOSE_TICKS(DOSE), .CLEAN_TICKS(CLEAN)) dut (
    .clock(clock), .reset(reset), .tick(tick), .req_asp(req_asp), .req_got(req_got), .adb(adb),
    .nivel(nivel), .VE(VE), .grant_asp(grant_asp), .grant_got(grant_got), .dose(dose),
    .limpeza(limpeza), .slot_done(slot_done), .state(state)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic after_slot();
    if (m_fert) begin
      m_mode = 4;
      m_left = CLEAN;
    end else m_mode = 0;
  endtask
  // Slots and flushes are modelled as countdowns of remaining ticks.
  task automatic model_step();
    bit empty, full, own;
    m_done = 0;
    if (!reset) begin
      m_mode = 0; m_left = 0; m_fert = 0; m_asp_next = 1;
      return;
    end
    empty = !(nivel == 3'b001 || nivel == 3'b011 || nivel == 3'b111);
    full = nivel == 3'b111;
    case (m_mode)
      0: if (empty) m_mode = 1;
         else if (req_asp && (!req_got || m_asp_next)) begin
           m_mode = 2; m_left = IRRIG; m_fert = adb; m_asp_next = 0; n_asp++;
         end else if (req_got) begin
           m_mode = 3; m_left = IRRIG; m_fert = 0; m_asp_next = 1; n_got++;
         end
      1: if (full) after_slot();
      2, 3: begin
        own = m_mode == 2 ? req_asp : req_got;
        if (empty) m_mode = 1;
        else if (!own) after_slot();
        else if (tick) begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1;
            n_done++;
            after_slot();
          end
        end
      end
      default: if (tick) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0; m_fert = 0; n_clean++;
        end
      end
    endcase
  endtask
  task automatic step();
    @(posedge clock);
    model_step();
    cyc++;
    #1;
    chk("state", 8'(state), 8'(m_mode));
    chk("VE", 8'(VE), 8'(m_mode == 1));
    chk("grant_asp", 8'(grant_asp), 8'(m_mode == 2));
    chk("grant_got", 8'(grant_got), 8'(m_mode == 3));
    chk("limpeza", 8'(limpeza), 8'(m_mode == 4));
    chk("dose", 8'(dose), 8'(m_mode == 2 && m_fert && (IRRIG - m_left) < DOSE));
    chk("slot_done", 8'(slot_done), 8'(m_done));
    chk("exclusive", 8'($countones({VE, grant_asp, grant_got, limpeza}) <= 1), 8'd1);
  endtask
  task automatic run(input int n, input int tick_pct);
    for (int i = 0; i < n; i++) begin
      tick = $urandom_range(99) < tick_pct;
      step();
    end
  endtask
  initial begin
    reset = 1'b0;
    run(3, 50);
    reset = 1'b1;
    nivel = 3'b000;
    run(3, 50);
    nivel = 3'b111;
    run(2, 50);
    req_asp = 1; req_got = 1; adb = 0;
    run(60, 100);
    req_got = 0; adb = 1;
    run(40, 100);
    adb = 0; req_asp = 0; req_got = 1;
    run(5, 100);
    nivel = 3'b000;
    run(3, 100);
    nivel = 3'b111; req_got = 0; req_asp = 1; adb = 1;
    run(7, 100);
    req_asp = 0; nivel = 3'b000;
    run(3, 100);
    nivel = 3'b111;
    run(8, 100);
    req_asp = 1; adb = 1;
    run(2, 100);
    reset = 1'b0;
    run(2, 100);
    reset = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(29) == 0) begin
        case ($urandom_range(9))
          0, 1: nivel = 3'b000;
          2: nivel = 3'b001;
          3: nivel = 3'b011;
          4: nivel = 3'($urandom);
          default: nivel = 3'b111;
        endcase
      end
      if ($urandom_range(39) == 0) req_asp = ~req_asp;
      if ($urandom_range(39) == 0) req_got = ~req_got;
      adb = $urandom_range(1);
      reset = $urandom_range(299) != 0;
      tick = $urandom_range(1);
      step();
    end
    chk("slots_seen", 8'(n_done > 10), 8'd1);
    chk("both_zones", 8'(n_asp > 5 && n_got > 5), 8'd1);
    chk("cleans_seen", 8'(n_clean > 2), 8'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
